// File: rtl/mcycle_arith.sv
// Multi-cycle multiply/divide unit: shift-add MUL and restoring DIV, one bit per cycle.
// Optional MUL early termination on exhausted multiplier bits via `MCYCLE_EARLY_TERM_EN.
module mcycle_arith #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic             Busy,
   output logic             Done
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      COMPUTE = 2'b01,
      DONE    = 2'b10
   } state_t;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      if (is_signed && v[WIDTH-1]) begin
         magnitude = {WIDTH{1'b0}} - v;
      end else begin
         magnitude = v;
      end
   endfunction

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mr_q;
   logic [WIDTH-1:0]   raw1_q;
   logic [WIDTH-1:0]   res1_q;
   logic [WIDTH-1:0]   res2_q;
   logic               is_div_q;
   logic               neg_q;
   logic               neg_rem_q;
   logic               dz_q;
   logic               busy_q;
   logic               done_q;

   logic               is_signed_s;
   logic [WIDTH-1:0]   mag1_s;
   logic [WIDTH-1:0]   mag2_s;
   logic [2*WIDTH-1:0] mul_acc_s;
   logic [WIDTH:0]     div_trial_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   div_rem_s;
   logic [2*WIDTH-1:0] div_acc_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quot_s;
   logic [WIDTH-1:0]   rem_s;
   logic               fin_s;

   // One datapath step for each operation plus the sign-corrected final values.
   always_comb begin
      is_signed_s = ~MCycleOp[0];
      mag1_s      = magnitude(Operand1, is_signed_s);
      mag2_s      = magnitude(Operand2, is_signed_s);

      if (mr_q[0]) begin
         mul_acc_s = acc_q + mcand_q;
      end else begin
         mul_acc_s = acc_q;
      end

      // acc_q holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
      div_trial_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge_s    = (div_trial_s >= {1'b0, mr_q});
      if (div_ge_s) begin
         div_rem_s = WIDTH'(div_trial_s - {1'b0, mr_q});
      end else begin
         div_rem_s = div_trial_s[WIDTH-1:0];
      end
      div_acc_s = {div_rem_s, acc_q[WIDTH-2:0], div_ge_s};

      if (neg_q) begin
         prod_s = {(2*WIDTH){1'b0}} - acc_q;
         quot_s = {WIDTH{1'b0}} - acc_q[WIDTH-1:0];
      end else begin
         prod_s = acc_q;
         quot_s = acc_q[WIDTH-1:0];
      end
      if (neg_rem_q) begin
         rem_s = {WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH];
      end else begin
         rem_s = acc_q[2*WIDTH-1:WIDTH];
      end

`ifdef MCYCLE_EARLY_TERM_EN
      fin_s = (cnt_q == LAST_CNT) ||
              (!is_div_q && (cnt_q != {CW{1'b0}}) && (mr_q == {WIDTH{1'b0}}));
`else
      fin_s = (cnt_q == LAST_CNT);
`endif
   end

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         cnt_q     <= {CW{1'b0}};
         acc_q     <= {(2*WIDTH){1'b0}};
         mcand_q   <= {(2*WIDTH){1'b0}};
         mr_q      <= {WIDTH{1'b0}};
         raw1_q    <= {WIDTH{1'b0}};
         res1_q    <= {WIDTH{1'b0}};
         res2_q    <= {WIDTH{1'b0}};
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (Start) begin
                  state_q   <= COMPUTE;
                  busy_q    <= 1'b1;
                  cnt_q     <= {CW{1'b0}};
                  is_div_q  <= MCycleOp[1];
                  neg_q     <= is_signed_s & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                  neg_rem_q <= is_signed_s & Operand1[WIDTH-1];
                  dz_q      <= MCycleOp[1] & (Operand2 == {WIDTH{1'b0}});
                  raw1_q    <= Operand1;
                  mr_q      <= mag2_s;
                  mcand_q   <= {{WIDTH{1'b0}}, mag1_s};
                  acc_q     <= MCycleOp[1] ? {{WIDTH{1'b0}}, mag1_s} : {(2*WIDTH){1'b0}};
               end else begin
                  busy_q <= 1'b0;
               end
            end
            COMPUTE: begin
               if (fin_s) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  if (!is_div_q) begin
                     res1_q <= prod_s[WIDTH-1:0];
                     res2_q <= prod_s[2*WIDTH-1:WIDTH];
                  end else if (dz_q) begin
                     res1_q <= {WIDTH{1'b1}};
                     res2_q <= raw1_q;
                  end else begin
                     res1_q <= quot_s;
                     res2_q <= rem_s;
                  end
               end else begin
                  cnt_q <= cnt_q + CW'(1);
                  if (is_div_q) begin
                     acc_q <= div_acc_s;
                  end else begin
                     acc_q   <= mul_acc_s;
                     mcand_q <= mcand_q << 1;
                     mr_q    <= mr_q >> 1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign Result1 = res1_q;
   assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_arith.sv
// Randomized bench for mcycle_arith against a plain-arithmetic reference model.
module tb_mcycle_arith;
   localparam int W = 32;

   logic          CLK = 1'b0;
   logic          RESET_N;
   logic          Start;
   logic [1:0]    MCycleOp;
   logic [W-1:0]  Operand1;
   logic [W-1:0]  Operand2;
   logic [W-1:0]  Result1;
   logic [W-1:0]  Result2;
   logic          Busy;
   logic          Done;

   int n_cmp = 0;
   int n_bad = 0;

   mcycle_arith #(.WIDTH(W)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .Start(Start), .MCycleOp(MCycleOp),
      .Operand1(Operand1), .Operand2(Operand2),
      .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r1, output logic [31:0] r2);
      logic signed [63:0] sa, sb, p, q, r;
      logic [63:0] up;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      r1 = 32'h0;
      r2 = 32'h0;
      case (op)
         2'b00: begin p = sa * sb; r1 = p[31:0]; r2 = p[63:32]; end
         2'b01: begin up = {32'h0, a} * {32'h0, b}; r1 = up[31:0]; r2 = up[63:32]; end
         2'b10: begin
            if (b == 32'h0) begin r1 = 32'hFFFF_FFFF; r2 = a; end
            else begin q = sa / sb; r = sa % sb; r1 = q[31:0]; r2 = r[31:0]; end
         end
         2'b11: begin
            if (b == 32'h0) begin r1 = 32'hFFFF_FFFF; r2 = a; end
            else begin r1 = a / b; r2 = a % b; end
         end
         default: begin r1 = 32'h0; r2 = 32'h0; end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef MCYCLE_EARLY_TERM_EN
      logic [31:0] mag;
      int n;
      if (!op[1]) begin
         mag = (op == 2'b00 && b[31]) ? (32'h0 - b) : b;
         n = 1;
         for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
         return n + 1;
      end
`endif
      return W + 1;
   endfunction

   // Starts at the launch edge; leaves Start high only when keep is set.
   task automatic wait_done(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit keep);
      logic [31:0] e1, e2;
      int n;
      bit busy_ok;
      model(op, a, b, e1, e2);
      @(posedge CLK);
      #1;
      busy_ok = Busy;
      n = 0;
      while (n < 200) begin
         Operand1 = $urandom;
         Operand2 = $urandom;
         MCycleOp = 2'($urandom);
         @(posedge CLK);
         n++;
         #1;
         if (Done) break;
         if (!Busy) busy_ok = 1'b0;
      end
      check("done_seen", {63'h0, Done}, 64'h1);
      check("latency", 64'(n), 64'(exp_lat(op, b)));
      check("busy_before_done", {63'h0, busy_ok}, 64'h1);
      check("busy_at_done", {63'h0, Busy}, 64'h0);
      check("result1", {32'h0, Result1}, {32'h0, e1});
      check("result2", {32'h0, Result2}, {32'h0, e2});
      if (!keep) Start = 1'b0;
      @(posedge CLK);
      #1;
      check("done_one_cycle", {63'h0, Done}, 64'h0);
      check("idle_not_busy", {63'h0, Busy}, 64'h0);
      check("result1_hold", {32'h0, Result1}, {32'h0, e1});
   endtask

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit keep);
      @(negedge CLK);
      MCycleOp = op;
      Operand1 = a;
      Operand2 = b;
      Start    = 1'b1;
      wait_done(op, a, b, keep);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a, b;
      RESET_N  = 1'b0;
      Start    = 1'b0;
      MCycleOp = 2'b00;
      Operand1 = 32'h0;
      Operand2 = 32'h0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy", {63'h0, Busy}, 64'h0);
      check("rst_done", {63'h0, Done}, 64'h0);
      check("rst_r1", {32'h0, Result1}, 64'h0);
      check("rst_r2", {32'h0, Result2}, 64'h0);
      @(negedge CLK);
      RESET_N = 1'b1;

      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
      launch(2'b01, 32'h0000_0005, 32'h0000_0003, 1'b0);
      launch(2'b11, 32'd100, 32'd7, 1'b0);
      launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      launch(2'b11, 32'h0000_1234, 32'h0000_0000, 1'b0);
      launch(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
      launch(2'b01, 32'h1234_5678, 32'h0000_0000, 1'b0);
      launch(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);

      // Start held through Done: ignored in DONE, relaunches from the next IDLE.
      launch(2'b00, 32'h0000_1001, 32'hFFFF_F000, 1'b1);
      MCycleOp = 2'b11;
      Operand1 = 32'hDEAD_BEEF;
      Operand2 = 32'h0000_0100;
      wait_done(2'b11, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'($urandom_range(0, 15));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: b = b >> $urandom_range(0, 31);
            default: ;
         endcase
         launch(op, a, b, 1'b0);
      end

      // Reset mid-operation, Start kept high through and after release.
      @(negedge CLK);
      MCycleOp = 2'b01;
      Operand1 = 32'h0001_0003;
      Operand2 = 32'h0000_0777;
      Start    = 1'b1;
      @(posedge CLK);
      repeat (10) @(posedge CLK);
      #1;
      RESET_N = 1'b0;
      #1;
      check("midrst_busy", {63'h0, Busy}, 64'h0);
      check("midrst_done", {63'h0, Done}, 64'h0);
      check("midrst_r1", {32'h0, Result1}, 64'h0);
      check("midrst_r2", {32'h0, Result2}, 64'h0);
      MCycleOp = 2'b10;
      Operand1 = 32'hFFFF_FFF9;
      Operand2 = 32'h0000_0002;
      repeat (2) @(negedge CLK);
      check("inrst_done", {63'h0, Done}, 64'h0);
      RESET_N = 1'b1;
      wait_done(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
